// File: rtl/decoder_scan_sequencer_if.sv
// Control and decoder-drive signals of the scan sequencer.
// The master side drives the scan controls. The slave side is the sequencer itself.
interface decoder_scan_sequencer_if #(
  parameter int ADDR_W  = 3,
  parameter int DWELL_W = 8
);
  localparam int N = 2 ** ADDR_W;

  logic               start;
  logic               stop;
  logic               mode;
  logic [DWELL_W-1:0] dwell;
  logic [N-1:0]       skip_mask;
  logic [ADDR_W-1:0]  addr;
  logic               enable;
  logic               busy;
  logic               done;
  logic               err;

  modport master (
    output start, stop, mode, dwell, skip_mask,
    input  addr, enable, busy, done, err
  );

  modport slave (
    input  start, stop, mode, dwell, skip_mask,
    output addr, enable, busy, done, err
  );
endinterface

// File: rtl/decoder_scan_sequencer.sv
// Walks the decoder lines in ascending order, skipping masked lines, holding each line for the dwell time.
// Each line gets one SEEK cycle, then D enable cycles, then one GAP cycle, so the line period is D+2.
module decoder_scan_sequencer #(
  parameter int ADDR_W  = 3,
  parameter int DWELL_W = 8
) (
  input logic                    clk,
  input logic                    rst_n,
  decoder_scan_sequencer_if.slave bus
);
  localparam int N = 2 ** ADDR_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SEEK  = 2'd1;
  localparam logic [1:0] S_DRIVE = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  logic [1:0]         state;
  logic [ADDR_W-1:0]  cursor;
  logic [ADDR_W-1:0]  addr_q;
  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] dwell_sh;
  logic [N-1:0]       mask_sh;
  logic               mode_sh;
  logic               pass_end;
  logic               enable_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;

  logic               fwd_hit;
  logic [ADDR_W-1:0]  fwd_idx;
  logic [ADDR_W-1:0]  low_idx;

  // Descending scan: the last hit written is the lowest qualifying index.
  always_comb begin
    fwd_hit = 1'b0;
    fwd_idx = '0;
    low_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!mask_sh[i]) begin
        low_idx = ADDR_W'(i);
        if (i >= int'(cursor)) begin
          fwd_hit = 1'b1;
          fwd_idx = ADDR_W'(i);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cursor   <= '0;
      addr_q   <= '0;
      cnt      <= '0;
      dwell_sh <= '0;
      mask_sh  <= '0;
      mode_sh  <= 1'b0;
      pass_end <= 1'b0;
      enable_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (state == S_IDLE) begin
        if (bus.start && !bus.stop) begin
          if (&bus.skip_mask) begin
            err_q <= 1'b1;
          end else begin
            dwell_sh <= (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;
            mask_sh  <= bus.skip_mask;
            mode_sh  <= bus.mode;
            cursor   <= '0;
            pass_end <= 1'b0;
            busy_q   <= 1'b1;
            state    <= S_SEEK;
          end
        end
      end else if (bus.stop) begin
        enable_q <= 1'b0;
        busy_q   <= 1'b0;
        state    <= S_IDLE;
      end else if (state == S_SEEK) begin
        pass_end <= 1'b0;
        if (!pass_end && fwd_hit) begin
          addr_q   <= fwd_idx;
          enable_q <= 1'b1;
          cnt      <= dwell_sh;
          state    <= S_DRIVE;
        end else if (mode_sh) begin
          addr_q   <= low_idx;
          enable_q <= 1'b1;
          cnt      <= dwell_sh;
          state    <= S_DRIVE;
        end else begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
      end else if (state == S_DRIVE) begin
        if (cnt == DWELL_W'(1)) begin
          enable_q <= 1'b0;
          cursor   <= addr_q + 1'b1;
          pass_end <= &addr_q;
          state    <= S_GAP;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end else begin
        state <= S_SEEK;
      end
    end
  end

  assign bus.addr   = addr_q;
  assign bus.enable = enable_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;
endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Bench for decoder_scan_sequencer: directed and randomized scans checked cycle by cycle against a line-list timing model.
module tb_decoder_scan_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  logic [2:0] prev_a = '0;
  logic       prev_en = 1'b0;
  logic [2:0] exp_last = '0;

  decoder_scan_sequencer_if #(.ADDR_W(3), .DWELL_W(8)) bus ();

  decoder_scan_sequencer #(.ADDR_W(3), .DWELL_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Enable and done are never both high, and addr only moves after a cycle with enable low.
  task automatic inv();
    chk("en_done_excl", {31'd0, bus.enable & bus.done}, 32'd0);
    if (bus.addr !== prev_a) chk("gap_before_addr_change", {31'd0, prev_en}, 32'd0);
    prev_a  = bus.addr;
    prev_en = bus.enable;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    inv();
  endtask

  // Start a scan and compare every cycle with the timing derived from the unmasked line list.
  task automatic run(input logic [7:0] mask, input logic [7:0] dw, input logic md,
                     input int ncyc, input int stop_t, input int restart_t);
    int L[$];
    int D, P, M, t_end;
    logic [2:0] ea;
    logic ee, eb, ed;
    for (int i = 0; i < 8; i++) if (!mask[i]) L.push_back(i);
    M = L.size();
    D = (dw == 0) ? 1 : int'(dw);
    P = D + 2;
    t_end = md ? ncyc : 1 + M * P + 2;
    bus.skip_mask = mask;
    bus.dwell     = dw;
    bus.mode      = md;
    bus.start     = 1'b1;
    tick();
    bus.start     = 1'b0;
    bus.dwell     = 8'($urandom);
    bus.skip_mask = 8'($urandom);
    bus.mode      = 1'($urandom);
    for (int t = 0; t <= t_end; t++) begin
      if (t == 0) begin
        ea = exp_last; ee = 1'b0; eb = 1'b1; ed = 1'b0;
      end else if (!md && t >= 1 + M * P) begin
        ea = 3'(L[M-1]); ee = 1'b0; eb = 1'b0; ed = (t == 1 + M * P);
      end else begin
        ea = 3'(L[((t - 1) / P) % M]); ee = ((t - 1) % P) < D; eb = 1'b1; ed = 1'b0;
      end
      chk("addr",   {29'd0, bus.addr},   {29'd0, ea});
      chk("enable", {31'd0, bus.enable}, {31'd0, ee});
      chk("busy",   {31'd0, bus.busy},   {31'd0, eb});
      chk("done",   {31'd0, bus.done},   {31'd0, ed});
      chk("err",    {31'd0, bus.err},    32'd0);
      exp_last = ea;
      if (t == stop_t) begin
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        chk("stop_enable", {31'd0, bus.enable}, 32'd0);
        chk("stop_busy",   {31'd0, bus.busy},   32'd0);
        chk("stop_done",   {31'd0, bus.done},   32'd0);
        chk("stop_addr",   {29'd0, bus.addr},   {29'd0, ea});
        break;
      end
      bus.start = (t == restart_t);
      tick();
    end
    bus.start = 1'b0;
    tick();
    chk("idle_after_run", {30'd0, bus.busy, bus.enable}, 32'd0);
  endtask

  initial begin
    logic [7:0] m;
    int dwr, p;
    logic md;
    bus.start = 1'b0; bus.stop = 1'b0; bus.mode = 1'b0;
    bus.dwell = '0;   bus.skip_mask = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_outputs", {bus.addr, bus.enable, bus.busy, bus.done, bus.err}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_after_rst", {31'd0, bus.busy}, 32'd0);

    // Full pass at dwell 2: done 33 cycles after the start edge.
    run(8'h00, 8'd2, 1'b0, 0, -1, -1);
    // Alternate lines at dwell 0 (treated as 1): done after 13 cycles.
    run(8'hAA, 8'd0, 1'b0, 0, -1, -1);
    // Continuous 0,7,0,7 with a start pulse while busy; stop during the second line's drive.
    run(8'h7E, 8'd3, 1'b1, 40, 16, 2);

    // Fully masked start is rejected with a single err pulse.
    bus.skip_mask = 8'hFF; bus.dwell = 8'd1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("err_pulse", {31'd0, bus.err}, 32'd1);
    chk("err_busy",  {31'd0, bus.busy}, 32'd0);
    tick();
    chk("err_once",  {31'd0, bus.err}, 32'd0);

    // Start together with stop does nothing.
    bus.skip_mask = 8'h00; bus.start = 1'b1; bus.stop = 1'b1;
    tick();
    bus.start = 1'b0; bus.stop = 1'b0;
    chk("startstop_err", {31'd0, bus.err}, 32'd0);
    tick();
    chk("startstop_idle", {30'd0, bus.busy, bus.enable}, 32'd0);

    // Asynchronous reset in the middle of a drive window.
    bus.skip_mask = 8'h00; bus.dwell = 8'd5; bus.mode = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    chk("pre_rst_enable", {31'd0, bus.enable}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst", {bus.addr, bus.enable, bus.busy, bus.done, bus.err}, 32'd0);
    #2 rst_n = 1'b1;
    prev_a = '0; prev_en = 1'b0; exp_last = '0;
    repeat (3) tick();
    chk("post_rst_idle", {30'd0, bus.busy, bus.enable}, 32'd0);

    // Randomized scans.
    for (int k = 0; k < 8; k++) begin
      m = 8'($urandom);
      if (m == 8'hFF) m = 8'h7F;
      dwr = $urandom_range(0, 4);
      md  = 1'($urandom_range(0, 1));
      p   = ((dwr == 0) ? 1 : dwr) + 2;
      if (md) run(m, 8'(dwr), 1'b1, 6 * p, $urandom_range(1, 5 * p), $urandom_range(1, 3));
      else    run(m, 8'(dwr), 1'b0, 0, -1, $urandom_range(1, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/decoder_scan_sequencer.md
Name: decoder_scan_sequencer

Overview:
- Sequential address generator that drives the A-inputs and enable of the two-to-four / three-to-eight decoder tree.
- Steps through the decoder's output lines in ascending order and holds each one for a programmable dwell time.
- Skips lines marked in a mask, and inserts one enable-low gap cycle between lines (break-before-make).
- Supports single-pass and continuous scan, with start/stop control and status outputs.

Parameters:
- ADDR_W, 3, decoder address width; number of lines N = 2**ADDR_W.
- DWELL_W, 8, width of the dwell-count input.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a scan; sampled only in IDLE.
- stop  input  1  abort the scan; sampled in every state.
- mode  input  1  0 = single pass, 1 = continuous (wrap to lowest unmasked line).
- dwell  input  DWELL_W  cycles enable is held per line; 0 is treated as 1.
- skip_mask  input  N  bit i = 1 means line i is never selected.
- addr  output  ADDR_W  decoder address (drives A2..A0).
- enable  output  1  decoder enable.
- busy  output  1  high from the cycle after an accepted start until return to IDLE.
- done  output  1  one-cycle pulse at normal completion of a single pass.
- err  output  1  one-cycle pulse when start is rejected.

Behaviour:
- Reset (asynchronous, rst_n low): state = IDLE; addr = 0, enable = 0, busy = 0, done = 0, err = 0; internal cursor and dwell counter = 0. Takes effect immediately, mid-scan included; enable falls without waiting for a clock edge.
- All outputs are registered.
- States: IDLE, SEEK, DRIVE, GAP.
- IDLE:
  - start = 1, stop = 0, skip_mask not all ones: latch dwell (0 becomes 1), mode and skip_mask into shadow registers; cursor = 0; go to SEEK; busy = 1 next cycle.
  - start = 1 with skip_mask all ones: err = 1 for one cycle; stay in IDLE; busy stays 0.
  - start and stop both high: stop wins; nothing happens; no err.
- SEEK (always exactly one cycle):
  - Select the lowest unmasked index >= cursor (shadow mask).
  - If found: addr = index, enable = 1, load the dwell counter, go to DRIVE.
  - If none and mode = 1: select the lowest unmasked index overall (wrap) and proceed the same way.
  - If none and mode = 0: done = 1 for one cycle, busy = 0, go to IDLE.
- DRIVE:
  - Hold addr and enable = 1 for exactly D cycles (D = latched dwell), counting down.
  - When the count expires: enable = 0, cursor = addr + 1, go to GAP.
  - When addr = N-1, cursor wraps to 0 and a pass-complete flag is set. Under mode = 0 this sends the next SEEK directly to done.
- GAP: one cycle with enable = 0 and addr holding its last value; then SEEK.
- Timing:
  - Start sampled at edge k: SEEK at k+1, enable high from k+2 for D cycles, GAP, then the next SEEK.
  - Per-line period is D+2 cycles.
  - Single pass over M unmasked lines: done pulses at cycle k+1+M*(D+2) relative to the start edge.
- stop = 1 in SEEK, DRIVE or GAP: next edge sets enable = 0, busy = 0 and goes to IDLE. done is not pulsed; addr holds its value.
- start is ignored while busy. The dwell, mode and skip_mask inputs are ignored after latching; changes take effect only at the next start.
- enable and done are never high in the same cycle.
- At most one decoder line is enabled at any time, and enable is always low for at least one cycle between different addr values.

Test Plan:
- Reset mid-DRIVE: assert rst_n = 0 asynchronously between edges -> enable, busy, addr, done and err are 0 immediately; after release the block idles until start.
- Single pass, skip_mask = 8'h00, dwell = 2, mode = 0:
  - addr sequence 0..7, each with enable high for 2 cycles and 1 gap cycle.
  - done pulses exactly 33 cycles after the start edge (1 + 8*4); busy falls with it.
- Mask and dwell zero, skip_mask = 8'b1010_1010, dwell = 0: addr visits 0, 2, 4, 6, each with enable high for 1 cycle; done after 1 + 4*3 = 13 cycles.
- Continuous, mode = 1, skip_mask = 8'b0111_1110: addr alternates 0, 7, 0, 7, ... with a gap between each and no done. stop asserted during DRIVE -> enable and busy low next edge; no done.
- Error and priority:
  - start with skip_mask = 8'hFF -> err pulses once, busy stays 0.
  - start and stop together in IDLE -> no activity, no err.
  - start pulsed while busy -> sequence unchanged.
- Scoreboard check on every run: at every cycle enable implies exactly one addr value; any cycle where addr changes is preceded by a cycle with enable = 0.
